// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Arbitrates the single register-file write port between the ALU result
//   path and the load (mem) result path. Load results normally win a
//   collision. A small counter tracks how many cycles in a row the ALU lost
//   while offering a result. Once that count reaches STARVE_LIMIT, the next
//   collision goes to the ALU instead.
//   Accepted results reach the register file one cycle later. Writes to x0
//   are accepted but dropped. A statistics counter counts the writes that
//   are actually performed.
//
// Parameters
//   STARVE_LIMIT  consecutive ALU losses before the ALU is forced a grant (1..15)
//   CNT_W         width of the writeback statistics counter
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   alu_valid_i/rd_i/data_i        ALU result offer
//   alu_ready_o                    ALU offer accepted this cycle (combinational)
//   mem_valid_i/rd_i/data_i        load result offer
//   mem_ready_o                    load offer accepted this cycle (combinational)
//   rf_stall_i                     register-file write port unavailable
//   rf_we_o/rf_waddr_o/rf_wdata_o  registered register-file write
//   wb_count_o                     registered count of performed writes
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid_i,
    input  logic [4:0]       alu_rd_i,
    input  logic [31:0]      alu_data_i,
    output logic             alu_ready_o,
    input  logic             mem_valid_i,
    input  logic [4:0]       mem_rd_i,
    input  logic [31:0]      mem_data_i,
    output logic             mem_ready_o,
    input  logic             rf_stall_i,
    output logic             rf_we_o,
    output logic [4:0]       rf_waddr_o,
    output logic [31:0]      rf_wdata_o,
    output logic [CNT_W-1:0] wb_count_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]       starve_q, starve_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0] wb_count_q, wb_count_d;

    logic             alu_starved;
    logic             grant_mem;
    logic             grant_alu;
    logic [4:0]       xfer_rd;
    logic [31:0]      xfer_data;
    logic             wr_en;

    // The ALU is owed a grant only if it is actually offering a result. An
    // idle ALU never blocks the load path.
    assign alu_starved = alu_valid_i && (starve_q == LIMIT);
    assign grant_mem   = mem_valid_i && !rf_stall_i && !reset && !alu_starved;
    assign grant_alu   = alu_valid_i && !rf_stall_i && !reset && !grant_mem;

    assign mem_ready_o = grant_mem;
    assign alu_ready_o = grant_alu;

    // The grants are one-hot, so a simple mux selects the winning payload.
    assign xfer_rd   = grant_mem ? mem_rd_i   : alu_rd_i;
    assign xfer_data = grant_mem ? mem_data_i : alu_data_i;
    assign wr_en     = (grant_mem || grant_alu) && (xfer_rd != 5'd0);

    // Starvation counter. It restarts whenever the ALU either wins or stops
    // offering a result. A stalled cycle is not counted as a loss, so the
    // counter freezes while the write port is stalled.
    always_comb begin
        starve_d = starve_q;
        if (!alu_valid_i || grant_alu) begin
            starve_d = 4'd0;
        end else if (!rf_stall_i) begin
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
        end
    end

    // Address and data change only on a real write. Idle cycles, stalls and
    // x0 writes leave the last written values visible.
    always_comb begin
        rf_we_d    = wr_en;
        rf_waddr_d = wr_en ? xfer_rd   : rf_waddr_q;
        rf_wdata_d = wr_en ? xfer_data : rf_wdata_q;
        wb_count_d = wr_en ? wb_count_q + {{(CNT_W-1){1'b0}}, 1'b1} : wb_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q   <= 4'd0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
            wb_count_q <= '0;
        end else begin
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            wb_count_q <= wb_count_d;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;
    assign wb_count_o = wb_count_q;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 3, max consecutive ALU losses before ALU is forced a grant (range 1..15).
REQ-002 Parameter: CNT_W, default 16, width of the writeback statistics counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 alu_valid_i  input  1  ALU result offered.
REQ-006 alu_rd_i  input  5  ALU destination register.
REQ-007 alu_data_i  input  32  ALU result.
REQ-008 alu_ready_o  output  1  ALU result accepted this cycle.
REQ-009 mem_valid_i  input  1  load result offered.
REQ-010 mem_rd_i  input  5  load destination register.
REQ-011 mem_data_i  input  32  load data.
REQ-012 mem_ready_o  output  1  load result accepted this cycle.
REQ-013 rf_stall_i  input  1  register-file write port unavailable.
REQ-014 rf_we_o  output  1  register-file write enable, registered.
REQ-015 rf_waddr_o  output  5  register-file write address, registered.
REQ-016 rf_wdata_o  output  32  register-file write data, registered.
REQ-017 wb_count_o  output  CNT_W  count of register writes performed, registered.

Function
REQ-018 Transfer on a port SHALL occur only in a cycle where its valid and ready are both 1.
REQ-019 grant_mem SHALL = mem_valid_i & ~rf_stall_i & ~reset & ~(alu_valid_i & starve_cnt == STARVE_LIMIT); grant_alu SHALL = alu_valid_i & ~rf_stall_i & ~reset & ~grant_mem.
REQ-020 mem_ready_o SHALL = grant_mem and alu_ready_o SHALL = grant_alu (combinational); at most one is 1 in any cycle.
REQ-021 starve_cnt (internal, 4 bits) SHALL increment, saturating at STARVE_LIMIT, when alu_valid_i & ~grant_alu & ~rf_stall_i.
REQ-022 starve_cnt SHALL clear to 0 when grant_alu or ~alu_valid_i; SHALL hold while rf_stall_i with alu_valid_i high.
REQ-023 On a transfer with rd != 0, the next cycle SHALL show rf_we_o=1, rf_waddr_o=rd, rf_wdata_o=data of the granted port (latency 1).
REQ-024 On a transfer with rd == 0, the transfer SHALL complete (ready=1) but rf_we_o SHALL be 0 next cycle; rf_waddr_o/rf_wdata_o hold.
REQ-025 In cycles with no transfer, rf_we_o SHALL be 0 next cycle and rf_waddr_o/rf_wdata_o SHALL hold previous values.
REQ-026 wb_count_o SHALL increment by 1 in the same edge that sets rf_we_o=1, wrapping modulo 2^CNT_W.
REQ-027 Unaccepted requests SHALL be held stable by the requester; the arbiter does not buffer them.
REQ-028 Simultaneous valid, starve_cnt < STARVE_LIMIT: mem wins; at starve_cnt == STARVE_LIMIT: ALU wins, counter clears.
REQ-029 rf_stall_i high SHALL force both readies to 0 and rf_we_o to 0 next cycle; no request is lost.

Reset
REQ-030 With reset high at a rising edge: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, wb_count_o=0, starve_cnt=0.
REQ-031 While reset is high both ready outputs SHALL be 0; an in-flight offer is not accepted and is re-arbitrated after reset.
REQ-032 First transfer is possible in the first cycle with reset low.

Verification
REQ-033 ALU only: alu_valid_i=1, rd=5, data=0x1234 -> alu_ready_o=1 same cycle; next cycle rf_we_o=1, waddr=5, wdata=0x1234, wb_count_o=1.
REQ-034 Contention, STARVE_LIMIT=3, both valid continuously, mem rd=7 / alu rd=9 -> grant pattern mem,mem,mem,alu,mem,mem,mem,alu; waddr 7,7,7,9 repeating.
REQ-035 rd=0: mem_valid_i=1, rd=0, data=0xFFFF -> mem_ready_o=1; next cycle rf_we_o=0, waddr/wdata unchanged, wb_count_o unchanged.
REQ-036 Stall: both valid, rf_stall_i=1 for 4 cycles with starve_cnt=2 -> no readies, rf_we_o=0, starve_cnt stays 2; after release mem wins once, then ALU.
REQ-037 Reset mid-operation: reset asserted during contention with starve_cnt=3 -> next cycle all outputs 0, starve_cnt=0; after release mem wins first.
REQ-038 Counter wrap, CNT_W=4: 16 consecutive writes with rd=1 -> wb_count_o returns to 0.
